fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction fetch stage of the in-order RV32 pipeline, directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues one single-word request at a time to instruction memory, which has variable latency and returns responses in order. It presents a registered {pc, insn, valid} slot to IF/ID. Branch/jump redirects from EX discard wrong-path and in-flight fetches; hazard stalls hold the slot.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset (must be word-aligned).
XLEN, 32, width of PC and instruction buses.

Ports:
clk  in  1  clock.
rst  in  1  reset, synchronous, active-low.
stall  in  1  downstream cannot accept; the slot is consumed when valid_out=1 and stall=0.
redirect_valid  in  1  EX redirect request this cycle.
redirect_pc  in  XLEN  redirect target.
imem_req  out  1  request strobe; memory always accepts; combinational from state.
imem_addr  out  XLEN  request address = fetch_pc.
imem_rvalid  in  1  response valid, at least 1 cycle after its request.
imem_rdata  in  XLEN  response instruction word.
pc_out  out  XLEN  PC of the presented instruction.
insn_out  out  XLEN  presented instruction.
valid_out  out  1  slot holds a correct-path instruction.
misalign_err  out  1  one-cycle pulse: redirect_pc[1:0] != 0.

Behaviour:
- State machine: FETCH, WAIT, DRAIN. Only one request is outstanding at any time.
- Reset (rst=0 at posedge):
  - state=FETCH, fetch_pc=RESET_PC.
  - pc_out=0, insn_out=NOP (32'h0000_0013), valid_out=0, misalign_err=0.
  - imem is reset by the same rst, so no pre-reset response is delivered after reset.
- imem_req = (state==FETCH) && !redirect_valid && (!valid_out || !stall).
  - A request is issued only if the slot is empty or is consumed that same cycle. The slot is therefore always empty when the response returns.
- Target alignment: tgt = {redirect_pc[XLEN-1:2],2'b00}. misalign_err is registered to (redirect_valid && redirect_pc[1:0]!=0) for exactly 1 cycle.
- FETCH:
  - redirect_valid: fetch_pc<=tgt, stay in FETCH, no request.
  - else if imem_req: go to WAIT.
  - else stay in FETCH.
- WAIT:
  - redirect_valid && imem_rvalid: drop the data, fetch_pc<=tgt, go to FETCH.
  - redirect_valid only: fetch_pc<=tgt, go to DRAIN.
  - imem_rvalid only: pc_out<=fetch_pc, insn_out<=imem_rdata, valid_out<=1, fetch_pc<=fetch_pc+4 (mod 2^XLEN, wraps from 0xFFFF_FFFC to 0), go to FETCH.
- DRAIN:
  - imem_rvalid: drop the data, go to FETCH.
  - redirect_valid in the same cycle: fetch_pc<=tgt. The latest redirect wins.
- Output slot:
  - Consumed (valid_out && !stall) with no new fill: valid_out<=0, insn_out<=NOP, pc_out holds.
  - Any redirect_valid: valid_out<=0, insn_out<=NOP. Redirect has priority over stall and over fill.
  - stall with no redirect: all outputs hold.
- Latency: request-to-valid_out = memory latency + 1 cycle.
- Throughput: with 1-cycle memory and no stall, 1 instruction per 2 cycles (next request is issued in the cycle the slot becomes visible).
- imem_addr always equals fetch_pc, and is stable while imem_req=1.

Decomposition:
- Shared package risc_five_pkg holds:
  - NOP_INSN = 32'h0000_0013.
  - fetch_state_t enum {FETCH, WAIT, DRAIN}.
  - PC_INCR = 4.
- No sub-module. The PC incrementer and alignment are inline.

Test Plan:
1. Reset release, 1-cycle memory, rdata=0xAAAA_0001 at 0x0, no stall:
   - Cycle 0: req addr 0x0.
   - Cycle 2: valid_out=1, pc_out=0x0, insn_out=0xAAAA_0001, and req addr 0x4 issued.
2. Slot valid with stall=1 held for 5 cycles:
   - imem_req=0 throughout and outputs stable.
   - Stall drops: req addr (pc_out+4) issued that same cycle.
3. Redirect to 0x100 during WAIT with 3-cycle latency:
   - Slot flushed: valid_out=0, insn_out=NOP.
   - FSM enters DRAIN and the late response is discarded.
   - Next req addr 0x100; no instruction from the old path ever reaches valid_out.
4. redirect_valid and imem_rvalid in the same cycle, target 0x200:
   - Data dropped, valid_out=0.
   - Next cycle: req addr 0x200.
5. Redirect to 0x102:
   - misalign_err=1 for one cycle.
   - Next req addr 0x100.
6. fetch_pc=0xFFFF_FFFC fetch completes: next req addr 0x0. Also assert rst=0 mid-WAIT: next cycle outputs at reset values and req addr RESET_PC.

Source files
------------

// File: rtl/risc_five_pkg.sv
// rtl/risc_five_pkg.sv - shared pipeline constants and fetch state encoding
package risc_five_pkg;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;
    localparam int          PC_INCR  = 4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32 instruction fetch stage with one outstanding imem request
module fetch_unit
    import risc_five_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] insn_out,
    output logic            valid_out,
    output logic            misalign_err
);

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] tgt;
    logic            fill;

    assign tgt       = {redirect_pc[XLEN-1:2], 2'b00};
    assign imem_addr = fetch_pc;
    assign fill      = (state == WAIT) && imem_rvalid && !redirect_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // A response arriving alongside a redirect is dropped and fetching restarts at once.
    always_comb begin
        state_nxt = state;
        case (state)
            FETCH: begin
                if (!redirect_valid && imem_req) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_nxt = FETCH;
                end else if (redirect_valid) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_rvalid) begin
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    always_comb begin
        imem_req = (state == FETCH) && !redirect_valid && (!valid_out || !stall);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc     <= RESET_PC;
            pc_out       <= '0;
            insn_out     <= XLEN'(NOP_INSN);
            valid_out    <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);

            if (redirect_valid) begin
                fetch_pc <= tgt;
            end else if (fill) begin
                fetch_pc <= fetch_pc + XLEN'(PC_INCR);
            end

            // Redirect flushes the slot ahead of both fill and stall hold.
            if (redirect_valid) begin
                valid_out <= 1'b0;
                insn_out  <= XLEN'(NOP_INSN);
            end else if (fill) begin
                pc_out    <= fetch_pc;
                insn_out  <= imem_rdata;
                valid_out <= 1'b1;
            end else if (valid_out && !stall) begin
                valid_out <= 1'b0;
                insn_out  <= XLEN'(NOP_INSN);
            end
        end
    end

endmodule
